mc_ctrl: RTL
============

# mc_ctrl

Multi-cycle control sequencer for the next-generation MIPS core. It replaces the purely combinational single-cycle decoder with a five-state FSM: FETCH, DECODE, EXEC, MEM, WB. It issues per-state write enables and datapath selects, and stretches data-memory accesses by a parameterised latency or a ready handshake. It sits beside the multi-cycle datapath under the core top, takes op/func from the datapath instruction register, and also keeps a retired-instruction counter.

## Interface
- MEM_LAT, 1: cycles spent in MEM when the handshake is compiled out; legal range ≥1.
- CNT_W, 32: width of the retired-instruction counter.
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- op  input  6  IR[31:26].
- func  input  6  IR[5:0].
- zero  input  1  ALU equality flag, used in EXEC for beq.
- mem_ready  input  1  data-memory done. Used only with MC_CTRL_MEMREADY_EN.
- pc_write, ir_write, reg_write, mem_read, mem_write  output  1 each  enables.
- npc_op  output  3  0 PC+4, 1 branch, 2 jump (j/jal), 3 jr.
- alu_op  output  4  0 add, 1 sub, 2 or, 3 lui (imm<<16).
- ext_op  output  3  0 zero-extend, 1 sign-extend.
- reg_dst_sel  output  3  0 rt, 1 rd, 2 $31.
- alu_src_sel  output  3  0 register B, 1 extended immediate.
- to_reg_sel  output  3  0 ALU, 1 memory, 2 PC.
- state  output  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- instr_done  output  1  high for one cycle, in the last cycle of each instruction.
- instret  output  CNT_W  count of retired instructions; wraps modulo 2^CNT_W.

## Operation
- Decoded instructions:
  - R-type (op 000000): addu (func 100001), subu (100011), jr (001000).
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
  - Anything else, including unknown func, is a nop.
- Outputs are a combinational function of state, op, func and zero. Selects not listed below are 0.
- FETCH
  - Asserts ir_write=1, pc_write=1, npc_op=0.
  - Next state: DECODE.
- DECODE
  - jal: reg_write=1, reg_dst_sel=2, to_reg_sel=2 (PC already holds PC+4), pc_write=1, npc_op=2. Next: FETCH.
  - j: pc_write=1, npc_op=2. Next: FETCH.
  - jr: pc_write=1, npc_op=3. Next: FETCH.
  - nop: next FETCH.
  - All others: next EXEC.
- EXEC
  - beq: alu_op=1, pc_write=zero, npc_op=1. Next: FETCH.
  - addu/subu: alu_op 0/1. Next: WB.
  - ori: alu_op=2, alu_src_sel=1, ext_op=0. Next: WB.
  - lui: alu_op=3, alu_src_sel=1. Next: WB.
  - lw/sw: alu_op=0, alu_src_sel=1, ext_op=1. Next: MEM.
- MEM
  - mem_read (lw) or mem_write (sw) is held high for every MEM cycle.
  - The address selects from EXEC are held.
  - On exit: sw goes to FETCH, lw goes to WB.
- WB
  - reg_write=1.
  - reg_dst_sel=1 for R-type, 0 otherwise.
  - to_reg_sel=1 for lw, 0 otherwise.
  - Next: FETCH.
- Retirement:
  - instr_done is high in every cycle whose next state is FETCH, excluding FETCH itself.
  - instret increments on that edge.
- While reset is low:
  - state=FETCH, wait counter=0, instret=0.
  - All enables and instr_done are forced to 0.
  - Reset is asynchronous: deassertion of state mid-instruction is immediate, with no partial write afterwards.

## Timing
- Instruction latency in cycles (W = MEM cycles, see below):
  - j, jal, jr, nop: 2.
  - beq: 3.
  - addu, subu, ori, lui: 4.
  - sw: 3+W.
  - lw: 4+W.
- The first FETCH occurs in the first clock after reset rises.
- beq not-taken still takes 3 cycles and leaves PC at PC+4.

## Configuration
- MC_CTRL_MEMREADY_EN undefined:
  - MEM lasts exactly MEM_LAT cycles, timed by an internal down-counter loaded on entry to MEM.
  - mem_ready is ignored.
  - W = MEM_LAT.
- MC_CTRL_MEMREADY_EN defined:
  - MEM exits on the first edge at which mem_ready=1; W ≥ 1 with no upper bound.
  - mem_ready high in the first MEM cycle gives W=1.
  - mem_ready is ignored in every other state.
  - MEM_LAT is unused.

## Test plan
- Reset, then addu (op 0, func 100001):
  - state sequence 0,1,2,4,0.
  - reg_write=1 with reg_dst_sel=1 only in WB.
  - instr_done pulses once; instret=1.
- beq:
  - With zero=1: pc_write=1, npc_op=1 in EXEC; 3 cycles.
  - With zero=0: pc_write=0 in EXEC.
- jal:
  - DECODE shows reg_write=1, reg_dst_sel=2, to_reg_sel=2, pc_write=1, npc_op=2.
  - Back in FETCH next cycle.
- lw:
  - Macro off, MEM_LAT=3: mem_read high for exactly 3 cycles; 7 cycles total.
  - Macro on, mem_ready raised on the 5th MEM cycle: 5 MEM cycles, then WB with to_reg_sel=1.
- Unknown op 111111: DECODE→FETCH, no enables beyond FETCH, instret increments.
- Reset pulled low mid-MEM of sw:
  - mem_write drops immediately; state=0; instret=0.
  - CNT_W=4 wrap check: 16 nops return instret to 0.

Source files
------------

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Five-state multi-cycle MIPS control sequencer with
//               retired-instruction counter. MC_CTRL_MEMREADY_EN selects
//               mem_ready handshake timing of MEM instead of MEM_LAT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic [2:0]       npc_op,
    output logic [3:0]       alu_op,
    output logic [2:0]       ext_op,
    output logic [2:0]       reg_dst_sel,
    output logic [2:0]       alu_src_sel,
    output logic [2:0]       to_reg_sel,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic       w_mem_done;

    logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lui;
    logic w_lw, w_sw, w_beq, w_j, w_jal, w_nop;

    assign w_rtype = (op == 6'b000000);
    assign w_addu  = w_rtype && (func == 6'b100001);
    assign w_subu  = w_rtype && (func == 6'b100011);
    assign w_jr    = w_rtype && (func == 6'b001000);
    assign w_ori   = (op == 6'b001101);
    assign w_lui   = (op == 6'b001111);
    assign w_lw    = (op == 6'b100011);
    assign w_sw    = (op == 6'b101011);
    assign w_beq   = (op == 6'b000100);
    assign w_j     = (op == 6'b000010);
    assign w_jal   = (op == 6'b000011);
    assign w_nop   = !(w_addu || w_subu || w_jr || w_ori || w_lui ||
                       w_lw || w_sw || w_beq || w_j || w_jal);

`ifdef MC_CTRL_MEMREADY_EN
    assign w_mem_done = mem_ready;
`else
    localparam int              c_WAIT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_INIT = c_WAIT_W'(MEM_LAT - 1);

    logic [c_WAIT_W-1:0] r_wait;
    logic                w_unused_mem_ready;

    assign w_unused_mem_ready = mem_ready;
    assign w_mem_done         = (r_wait == '0);

    // Loaded on the EXEC->MEM edge so the first MEM cycle already sees MEM_LAT-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait <= '0;
        end else if (r_state == c_ST_EXEC && w_next == c_ST_MEM) begin
            r_wait <= c_WAIT_INIT;
        end else if (r_state == c_ST_MEM && r_wait != '0) begin
            r_wait <= r_wait - 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_FETCH;
            instret <= '0;
        end else begin
            r_state <= w_next;
            if (instr_done) begin
                instret <= instret + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = c_ST_FETCH;
        case (r_state)
            c_ST_FETCH:  w_next = c_ST_DECODE;
            c_ST_DECODE: w_next = (w_jal || w_j || w_jr || w_nop) ? c_ST_FETCH : c_ST_EXEC;
            c_ST_EXEC: begin
                if (w_beq)             w_next = c_ST_FETCH;
                else if (w_lw || w_sw) w_next = c_ST_MEM;
                else                   w_next = c_ST_WB;
            end
            c_ST_MEM: begin
                if (!w_mem_done) w_next = c_ST_MEM;
                else if (w_lw)   w_next = c_ST_WB;
                else             w_next = c_ST_FETCH;
            end
            c_ST_WB:     w_next = c_ST_FETCH;
            default:     w_next = c_ST_FETCH;
        endcase
    end

    assign state      = r_state;
    assign instr_done = reset && (r_state != c_ST_FETCH) && (w_next == c_ST_FETCH);

    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        npc_op      = 3'd0;
        alu_op      = 4'd0;
        ext_op      = 3'd0;
        reg_dst_sel = 3'd0;
        alu_src_sel = 3'd0;
        to_reg_sel  = 3'd0;
        case (r_state)
            c_ST_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            c_ST_DECODE: begin
                if (w_jal) begin
                    reg_write   = 1'b1;
                    reg_dst_sel = 3'd2;
                    to_reg_sel  = 3'd2;
                    pc_write    = 1'b1;
                    npc_op      = 3'd2;
                end else if (w_j) begin
                    pc_write = 1'b1;
                    npc_op   = 3'd2;
                end else if (w_jr) begin
                    pc_write = 1'b1;
                    npc_op   = 3'd3;
                end
            end
            c_ST_EXEC: begin
                if (w_beq) begin
                    alu_op   = 4'd1;
                    pc_write = zero;
                    npc_op   = 3'd1;
                end else if (w_subu) begin
                    alu_op = 4'd1;
                end else if (w_ori) begin
                    alu_op      = 4'd2;
                    alu_src_sel = 3'd1;
                end else if (w_lui) begin
                    alu_op      = 4'd3;
                    alu_src_sel = 3'd1;
                end else if (w_lw || w_sw) begin
                    alu_src_sel = 3'd1;
                    ext_op      = 3'd1;
                end
            end
            c_ST_MEM: begin
                alu_src_sel = 3'd1;
                ext_op      = 3'd1;
                mem_read    = w_lw;
                mem_write   = w_sw;
            end
            c_ST_WB: begin
                reg_write   = 1'b1;
                reg_dst_sel = w_rtype ? 3'd1 : 3'd0;
                to_reg_sel  = w_lw ? 3'd1 : 3'd0;
            end
            default: ;
        endcase
        // Enables are masked while reset is held so nothing writes during reset.
        if (!reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

endmodule
`default_nettype wire
